direct_map_cache_ctrl: RTL and testbench
========================================

# direct_map_cache_ctrl

Cache controller FSM for the direct-mapped cache subsystem, between the CPU-side request port and the cache array and main memory. It accepts one word-addressed read or write at a time and performs the tag lookup. On a read miss it fetches the word from main memory and fills the cache line. Writes are write-through, update-on-hit and no-allocate. It also keeps saturating hit and miss counters.

## Interface
Parameters:
- TAG_W, 9, tag width (address bits [ADDR_W-1:IDX_W])
- IDX_W, 3, index width (address bits [IDX_W-1:0]); 2**IDX_W lines
- DATA_W, 32, data word width
- CNT_W, 16, statistics counter width
- ADDR_W is derived as TAG_W+IDX_W (12); it is not overridable

Ports:
- clk  in  1  single clock; all state changes on posedge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  CPU request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  response available
- resp_ready  in  1  CPU accepts response
- resp_rdata  out  DATA_W  read data (0 for writes)
- resp_hit  out  1  request hit in cache
- cache_index  out  IDX_W  cache line select
- cache_write  out  1  cache line write enable (sampled at posedge)
- cache_tag_in  out  TAG_W  tag to write
- cache_data_in  out  DATA_W  data to write
- cache_valid  in  1  combinational valid of the selected line
- cache_tag_out  in  TAG_W  combinational tag of the selected line
- cache_data_out  in  DATA_W  combinational data of the selected line
- mem_addr  out  ADDR_W  memory address
- mem_write  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, registered inside memory (valid the cycle after the address is presented)
- hit_count  out  CNT_W  saturating hit counter
- miss_count  out  CNT_W  saturating miss counter

## Operation
- **Handshake:** a request is accepted on a posedge with req_valid && req_ready. At acceptance the controller latches addr, we and wdata into a_q, we_q and wd_q. A response completes on a posedge with resp_valid && resp_ready.
- **Address split:** tag_q = a_q[ADDR_W-1:IDX_W], idx_q = a_q[IDX_W-1:0].
- **Cache index:** cache_index = idx_q in every non-IDLE state.
- **States:** IDLE, LOOKUP, MEM_RD, MEM_WAIT, WRITE, RESP.
- **IDLE:**
  - req_ready = 1.
  - On acceptance, go to LOOKUP.
- **LOOKUP:**
  - hit = cache_valid && (cache_tag_out == tag_q); hit_q <= hit.
  - Increment hit_count on a hit, otherwise miss_count; this applies to reads and writes.
  - Read hit: resp_rdata <= cache_data_out, go to RESP.
  - Read miss: go to MEM_RD.
  - Write: go to WRITE.
- **MEM_RD:** mem_addr = a_q, mem_write = 0; go to MEM_WAIT.
- **MEM_WAIT:**
  - mem_addr is still a_q.
  - Drive cache_write = 1, cache_tag_in = tag_q, cache_data_in = mem_rdata.
  - resp_rdata <= mem_rdata; go to RESP.
- **WRITE:**
  - mem_write = 1, mem_addr = a_q, mem_wdata = wd_q.
  - If hit_q: cache_write = 1, cache_tag_in = tag_q, cache_data_in = wd_q.
  - Go to RESP.
- **RESP:**
  - resp_valid = 1; resp_rdata and resp_hit = hit_q are held stable.
  - When resp_ready is high, go to IDLE.
- **Counters:** saturate at all-ones and never wrap.
- **Enable outputs:** cache_write and mem_write are decoded from state only, so they are glitch-free and 0 in IDLE, LOOKUP and RESP.
- **Back-to-back traffic:** the controller is non-pipelined; a new request is accepted at the earliest in the cycle after the RESP handshake.

## Timing
- **Reset (rst_n low):**
  - state = IDLE; a_q, wd_q, resp_rdata, hit_q = 0; both counters = 0.
  - All outputs 0 except req_ready = 1.
- **Reset mid-operation:** aborts immediately. No cache_write or mem_write is asserted after rst_n falls, and no response is issued for the aborted request.
- **Latency,** counted as posedges from acceptance to the first cycle resp_valid is high:
  - read hit: 2 (LOOKUP, RESP)
  - read miss: 4 (LOOKUP, MEM_RD, MEM_WAIT, RESP)
  - write: 3 (LOOKUP, WRITE, RESP)
- **resp_ready held low:** the controller stays in RESP indefinitely with outputs stable.
- **req_valid during a non-IDLE state:** ignored; req_ready = 0.
- **Write hit:** the cache and memory are updated on the same posedge (WRITE exit).
- **Read-miss fill:** the cache line is written at the MEM_WAIT exit, so a following read to the same address hits.

## Structure
- Package direct_map_cache_pkg holds:
  - the state enum
  - default width constants TAG_W, IDX_W, DATA_W, CNT_W
  - an address-split helper
- Sub-module cache_stat_counter: a CNT_W saturating counter with inc and rst_n; instantiated twice, once for hits and once for misses.

## Test plan
Bench-model setup: memory word[a] = a for a in 0..7; cache line 1 = valid, tag 0, data 1; line 3 = invalid.

1. Read 0x001 → resp_rdata = 1, resp_hit = 1, resp_valid 2 cycles after acceptance; no mem or cache writes; hit_count = 1.
2. Read 0x003 (line invalid) → mem read of 0x003, cache line 3 written with tag 0 and data 3, resp_rdata = 3, resp_hit = 0, latency 4; a repeated read of 0x003 then hits.
3. Write 0x001 with 0xDEADBEEF (hit), then read 0x001 → memory[1] and cache line 1 are both 0xDEADBEEF, and the read hits with 0xDEADBEEF.
4. Write 0x00A (tag 1, index 2, line 2 holds tag 0) with 0x55 → mem_write only, cache_write stays 0, resp_hit = 0, miss_count increments.
5. Hold resp_ready low for 5 cycles during a read-hit response → resp_valid and resp_rdata stay stable and req_ready stays 0; the handshake then returns the controller to IDLE.
6. Assert rst_n low while in MEM_WAIT → cache_write drops immediately, outputs return to reset values, the counters clear, and the next request operates normally.

Source files
------------

// File: rtl/direct_map_cache_pkg.sv
// Shared types, default widths and address-split helpers for the direct-mapped cache controller.
package direct_map_cache_pkg;

    localparam int TAG_W  = 9;
    localparam int IDX_W  = 3;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MEM_RD,
        ST_MEM_WAIT,
        ST_WRITE,
        ST_RESP
    } state_t;

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int idx_w);
        return addr >> idx_w;
    endfunction

    function automatic logic [31:0] addr_idx(input logic [31:0] addr, input int idx_w);
        return addr & ((32'd1 << idx_w) - 32'd1);
    endfunction

endpackage

// File: rtl/direct_map_cache_ctrl_counter.sv
// Saturating statistics counter; holds at all-ones instead of wrapping.
module cache_stat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/direct_map_cache_ctrl.sv
// Direct-mapped cache controller: tag lookup, read-miss fill, write-through no-allocate writes,
// and saturating hit/miss statistics.
module direct_map_cache_ctrl #(
    parameter int TAG_W  = direct_map_cache_pkg::TAG_W,
    parameter int IDX_W  = direct_map_cache_pkg::IDX_W,
    parameter int DATA_W = direct_map_cache_pkg::DATA_W,
    parameter int CNT_W  = direct_map_cache_pkg::CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [TAG_W+IDX_W-1:0] req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DATA_W-1:0]      resp_rdata,
    output logic                   resp_hit,
    output logic [IDX_W-1:0]       cache_index,
    output logic                   cache_write,
    output logic [TAG_W-1:0]       cache_tag_in,
    output logic [DATA_W-1:0]      cache_data_in,
    input  logic                   cache_valid,
    input  logic [TAG_W-1:0]       cache_tag_out,
    input  logic [DATA_W-1:0]      cache_data_out,
    output logic [TAG_W+IDX_W-1:0] mem_addr,
    output logic                   mem_write,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic [CNT_W-1:0]       hit_count,
    output logic [CNT_W-1:0]       miss_count
);

    import direct_map_cache_pkg::*;

    localparam int ADDR_W = TAG_W + IDX_W;

    state_t              state;
    logic [ADDR_W-1:0]   a_q;
    logic                we_q;
    logic [DATA_W-1:0]   wd_q;
    logic                hit_q;
    logic [TAG_W-1:0]    tag_q;
    logic [IDX_W-1:0]    idx_q;
    logic                hit;
    logic                fill_wr;
    logic                hit_wr;

    assign tag_q = TAG_W'(addr_tag(32'(a_q), IDX_W));
    assign idx_q = IDX_W'(addr_idx(32'(a_q), IDX_W));
    assign hit   = cache_valid && (cache_tag_out == tag_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            a_q        <= '0;
            we_q       <= 1'b0;
            wd_q       <= '0;
            resp_rdata <= '0;
            hit_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        a_q   <= req_addr;
                        we_q  <= req_we;
                        wd_q  <= req_wdata;
                        state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    hit_q <= hit;
                    if (we_q) begin
                        resp_rdata <= '0;
                        state      <= ST_WRITE;
                    end else if (hit) begin
                        resp_rdata <= cache_data_out;
                        state      <= ST_RESP;
                    end else begin
                        state <= ST_MEM_RD;
                    end
                end
                ST_MEM_RD:   state <= ST_MEM_WAIT;
                ST_MEM_WAIT: begin
                    resp_rdata <= mem_rdata;
                    state      <= ST_RESP;
                end
                ST_WRITE:    state <= ST_RESP;
                ST_RESP: begin
                    if (resp_ready) state <= ST_IDLE;
                end
                default:     state <= ST_IDLE;
            endcase
        end
    end

    // Strobes decode from the state register alone so they cannot glitch and drop at once on reset.
    assign fill_wr       = (state == ST_MEM_WAIT);
    assign hit_wr        = (state == ST_WRITE) && hit_q;
    assign req_ready     = (state == ST_IDLE);
    assign resp_valid    = (state == ST_RESP);
    assign resp_hit      = (state == ST_RESP) && hit_q;
    assign cache_index   = (state == ST_IDLE) ? '0 : idx_q;
    assign cache_write   = fill_wr || hit_wr;
    assign cache_tag_in  = cache_write ? tag_q : '0;
    assign cache_data_in = fill_wr ? mem_rdata : (hit_wr ? wd_q : '0);
    assign mem_write     = (state == ST_WRITE);
    assign mem_addr      = (state == ST_MEM_RD || state == ST_MEM_WAIT || state == ST_WRITE) ? a_q : '0;
    assign mem_wdata     = mem_write ? wd_q : '0;

    cache_stat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   ((state == ST_LOOKUP) && hit),
        .count (hit_count)
    );

    cache_stat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   ((state == ST_LOOKUP) && !hit),
        .count (miss_count)
    );

endmodule

// File: tb/tb_direct_map_cache_ctrl.sv
// Directed bench for direct_map_cache_ctrl with a behavioural cache array and registered memory.
module tb_direct_map_cache_ctrl;

    localparam int TAG_W  = 9;
    localparam int IDX_W  = 3;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int ADDR_W = TAG_W + IDX_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_hit;
    logic [IDX_W-1:0]  cache_index;
    logic              cache_write;
    logic [TAG_W-1:0]  cache_tag_in;
    logic [DATA_W-1:0] cache_data_in;
    logic              cache_valid;
    logic [TAG_W-1:0]  cache_tag_out;
    logic [DATA_W-1:0] cache_data_out;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    always #5 clk = ~clk;

    direct_map_cache_ctrl #(
        .TAG_W (TAG_W), .IDX_W (IDX_W), .DATA_W (DATA_W), .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_hit       (resp_hit),
        .cache_index    (cache_index),
        .cache_write    (cache_write),
        .cache_tag_in   (cache_tag_in),
        .cache_data_in  (cache_data_in),
        .cache_valid    (cache_valid),
        .cache_tag_out  (cache_tag_out),
        .cache_data_out (cache_data_out),
        .mem_addr       (mem_addr),
        .mem_write      (mem_write),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    // Cache array and memory models; contents are seeded on the first clock edge.
    logic [7:0]        c_valid;
    logic [TAG_W-1:0]  c_tag  [8];
    logic [DATA_W-1:0] c_data [8];
    logic [DATA_W-1:0] mem    [4096];
    logic              seeded = 1'b0;

    assign cache_valid    = c_valid[cache_index];
    assign cache_tag_out  = c_tag[cache_index];
    assign cache_data_out = c_data[cache_index];

    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 4096; i++) mem[i] <= DATA_W'(i);
            for (int i = 0; i < 8; i++) begin
                c_tag[i]  <= '0;
                c_data[i] <= DATA_W'(i);
            end
            c_valid   <= 8'b0000_0110;
            mem_rdata <= '0;
            seeded    <= 1'b1;
        end else begin
            mem_rdata <= mem[mem_addr];
            if (mem_write) mem[mem_addr] <= mem_wdata;
            if (cache_write) begin
                c_valid[cache_index] <= 1'b1;
                c_tag[cache_index]   <= cache_tag_in;
                c_data[cache_index]  <= cache_data_in;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
        logic              exp_hit;
        int                exp_lat;
        int                exp_mw;
        int                exp_cw;
    } vec_t;

    vec_t vecs [7];

    // Issues one request, counts posedges from acceptance to resp_valid and the write strobes seen.
    task automatic run_txn(input vec_t v, input string nm, input bit do_ack);
        int lat;
        int mw;
        int cw;
        mw = 0;
        cw = 0;
        @(negedge clk);
        chk({nm, " req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req_valid = 1'b0;
        while (!resp_valid && lat < 20) begin
            if (mem_write)   mw++;
            if (cache_write) cw++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({nm, " latency"}, 64'(lat), 64'(v.exp_lat));
        chk({nm, " rdata"}, 64'(resp_rdata), 64'(v.exp_rdata));
        chk({nm, " hit"}, 64'(resp_hit), 64'(v.exp_hit));
        chk({nm, " mem_write cycles"}, 64'(mw), 64'(v.exp_mw));
        chk({nm, " cache_write cycles"}, 64'(cw), 64'(v.exp_cw));
        if (do_ack) @(posedge clk);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " req_ready"},   64'(req_ready),   64'd1);
        chk({nm, " resp_valid"},  64'(resp_valid),  64'd0);
        chk({nm, " resp_rdata"},  64'(resp_rdata),  64'd0);
        chk({nm, " resp_hit"},    64'(resp_hit),    64'd0);
        chk({nm, " cache_write"}, 64'(cache_write), 64'd0);
        chk({nm, " mem_write"},   64'(mem_write),   64'd0);
        chk({nm, " mem_addr"},    64'(mem_addr),    64'd0);
        chk({nm, " cache_index"}, 64'(cache_index), 64'd0);
        chk({nm, " hit_count"},   64'(hit_count),   64'd0);
        chk({nm, " miss_count"},  64'(miss_count),  64'd0);
    endtask

    initial begin
        vec_t v;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;

        //               we    addr     wdata         rdata         hit  lat mw cw
        vecs[0] = '{1'b0, 12'h001, 32'h0,        32'h1,        1'b1, 2, 0, 0};
        vecs[1] = '{1'b0, 12'h003, 32'h0,        32'h3,        1'b0, 4, 0, 1};
        vecs[2] = '{1'b0, 12'h003, 32'h0,        32'h3,        1'b1, 2, 0, 0};
        vecs[3] = '{1'b1, 12'h001, 32'hDEADBEEF, 32'h0,        1'b1, 3, 1, 1};
        vecs[4] = '{1'b0, 12'h001, 32'h0,        32'hDEADBEEF, 1'b1, 2, 0, 0};
        vecs[5] = '{1'b1, 12'h00A, 32'h55,       32'h0,        1'b0, 3, 1, 0};
        vecs[6] = '{1'b0, 12'h00A, 32'h0,        32'h55,       1'b0, 4, 0, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i), 1'b1);
        end
        @(negedge clk);
        chk("mem[1] after write hit", 64'(mem[1]), 64'hDEADBEEF);
        chk("line1 data after write hit", 64'(c_data[1]), 64'hDEADBEEF);
        chk("mem[A] after write miss", 64'(mem[10]), 64'h55);
        chk("line3 tag after fill", 64'(c_tag[3]), 64'd0);
        chk("hit_count after table", 64'(hit_count), 64'd4);
        chk("miss_count after table", 64'(miss_count), 64'd3);

        // Response back-pressure: resp_ready low for five cycles with a competing request pending.
        resp_ready = 1'b0;
        v = '{1'b0, 12'h001, 32'h0, 32'hDEADBEEF, 1'b1, 2, 0, 0};
        run_txn(v, "stall", 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 12'h003;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d resp_valid", i), 64'(resp_valid), 64'd1);
            chk($sformatf("stall%0d rdata", i), 64'(resp_rdata), 64'hDEADBEEF);
            chk($sformatf("stall%0d req_ready", i), 64'(req_ready), 64'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("stall release req_ready", 64'(req_ready), 64'd1);
        chk("stall release resp_valid", 64'(resp_valid), 64'd0);
        chk("hit_count after stall", 64'(hit_count), 64'd5);

        // Reset while the read-miss fill is being presented to the cache.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 12'h005;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pre-abort cache_write", 64'(cache_write), 64'd1);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("abort");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort line5 not filled", 64'(c_valid[5]), 64'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort no response", 64'(resp_valid), 64'd0);
        end

        v = '{1'b0, 12'h001, 32'h0, 32'hDEADBEEF, 1'b1, 2, 0, 0};
        run_txn(v, "post-abort", 1'b1);
        @(negedge clk);
        chk("post-abort hit_count", 64'(hit_count), 64'd1);

        // Counter saturation at all-ones.
        for (int i = 0; i < 20; i++) run_txn(v, $sformatf("sat_hit%0d", i), 1'b1);
        @(negedge clk);
        chk("hit_count saturated", 64'(hit_count), 64'd15);
        chk("miss_count before misses", 64'(miss_count), 64'd0);
        for (int i = 0; i < 10; i++) begin
            v = '{1'b0, 12'h002, 32'h0, 32'h2, 1'b0, 4, 0, 1};
            run_txn(v, $sformatf("sat_missA%0d", i), 1'b1);
            v = '{1'b0, 12'h00A, 32'h0, 32'h55, 1'b0, 4, 0, 1};
            run_txn(v, $sformatf("sat_missB%0d", i), 1'b1);
        end
        @(negedge clk);
        chk("miss_count saturated", 64'(miss_count), 64'd15);
        chk("hit_count held", 64'(hit_count), 64'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
